// File: rtl/axil_seg_pkg.sv
// Shared constants and state types for the AXI-Lite seven-segment register file.
package axil_seg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/axil_seg_regfile_sevenseg.sv
// Eight-digit multiplexed seven-segment driver; segments and anodes are active-low.
module SevenSegmentController #(
  parameter int SCAN_BITS = 17
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [31:0] value,
  output logic [7:0]  segment,
  output logic [7:0]  anode
);
  import axil_seg_pkg::*;

  logic [SCAN_BITS+2:0] scan_cnt_reg;
  logic [2:0]           digit;
  logic [3:0]           nibble;

  // Free-running refresh counter; the top three bits pick the lit digit.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) scan_cnt_reg <= '0;
    else          scan_cnt_reg <= scan_cnt_reg + 1'b1;
  end

  assign digit   = scan_cnt_reg[SCAN_BITS+2:SCAN_BITS];
  assign nibble  = value[{digit, 2'b00} +: 4];
  // Decimal point (bit 7) is held off.
  assign segment = {1'b1, ~hex_to_seg(nibble)};

  for (genvar gi = 0; gi < 8; gi++) begin : g_anode
    assign anode[gi] = (digit != 3'(gi));
  end

endmodule

// File: rtl/axil_seg_regfile.sv
// AXI4-Lite register file with a display-select register feeding a seven-segment display.
module axil_seg_regfile #(
  parameter int         NUM_REGS     = 4,
  parameter logic [3:0] DISP_DEFAULT = 4'd0,
  parameter int         SCAN_BITS    = 17
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [31:0] AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [2:0]  AWPROT,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [31:0] ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [2:0]  ARPROT,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [7:0]  segment,
  output logic [7:0]  anode
);
  import axil_seg_pkg::*;

  localparam logic [3:0] DISP_IDX = 4'(NUM_REGS);

  wr_state_t wr_state_reg, wr_state_next;
  rd_state_t rd_state_reg, rd_state_next;

  logic [NUM_REGS-1:0][31:0] regs_reg;
  logic [3:0]  disp_sel_reg;
  logic [3:0]  aw_idx_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic [1:0]  bresp_reg;
  logic [31:0] rdata_reg;
  logic [1:0]  rresp_reg;

  logic        wr_commit, aw_latch, w_latch, wr_mapped;
  logic [3:0]  wr_idx, wr_strb, rd_idx;
  logic [31:0] wr_data, rd_lookup_data, disp_value;
  logic [1:0]  rd_lookup_resp;
  logic        unused_ok;

  assign unused_ok = ^{AWPROT, ARPROT, AWADDR[31:6], AWADDR[1:0], ARADDR[31:6], ARADDR[1:0]};

  // Write FSM: handshakes, and the effective address/data/strobe of the committing write.
  always_comb begin
    wr_state_next = wr_state_reg;
    AWREADY       = 1'b0;
    WREADY        = 1'b0;
    BVALID        = 1'b0;
    wr_commit     = 1'b0;
    aw_latch      = 1'b0;
    w_latch       = 1'b0;
    wr_idx        = AWADDR[5:2];
    wr_data       = WDATA;
    wr_strb       = WSTRB;
    case (wr_state_reg)
      WR_IDLE: begin
        AWREADY = 1'b1;
        WREADY  = 1'b1;
        if (AWVALID && WVALID) begin
          wr_commit     = 1'b1;
          wr_state_next = WR_RESP;
        end else if (AWVALID) begin
          aw_latch      = 1'b1;
          wr_state_next = WR_ADDR;
        end else if (WVALID) begin
          w_latch       = 1'b1;
          wr_state_next = WR_DATA;
        end
      end
      WR_ADDR: begin
        WREADY = 1'b1;
        wr_idx = aw_idx_reg;
        if (WVALID) begin
          wr_commit     = 1'b1;
          wr_state_next = WR_RESP;
        end
      end
      WR_DATA: begin
        AWREADY = 1'b1;
        wr_data = wdata_reg;
        wr_strb = wstrb_reg;
        if (AWVALID) begin
          wr_commit     = 1'b1;
          wr_state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        BVALID = 1'b1;
        if (BREADY) wr_state_next = WR_IDLE;
      end
      default: wr_state_next = WR_IDLE;
    endcase
  end

  assign wr_mapped = (wr_idx <= DISP_IDX);

  // State registers for both channel FSMs.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_state_reg <= WR_IDLE;
      rd_state_reg <= RD_IDLE;
    end else begin
      wr_state_reg <= wr_state_next;
      rd_state_reg <= rd_state_next;
    end
  end

  // Hold whichever half of a split write arrived first, and capture the response code.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_idx_reg <= '0;
      wdata_reg  <= '0;
      wstrb_reg  <= '0;
      bresp_reg  <= RESP_OKAY;
    end else begin
      if (aw_latch) aw_idx_reg <= AWADDR[5:2];
      if (w_latch) begin
        wdata_reg <= WDATA;
        wstrb_reg <= WSTRB;
      end
      if (wr_commit) bresp_reg <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Byte-lane register update; unmapped indices match nothing and leave state untouched.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      regs_reg     <= '0;
      disp_sel_reg <= DISP_DEFAULT;
    end else if (wr_commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == 4'(i)) begin
          for (int k = 0; k < 4; k++) begin
            if (wr_strb[k]) regs_reg[i][8*k +: 8] <= wr_data[8*k +: 8];
          end
        end
      end
      if (wr_idx == DISP_IDX && wr_strb[0]) disp_sel_reg <= wr_data[3:0];
    end
  end

  assign BRESP = bresp_reg;

  // Read address decode against the current (pre-write) register contents.
  always_comb begin
    rd_idx         = ARADDR[5:2];
    rd_lookup_data = '0;
    rd_lookup_resp = RESP_SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == 4'(i)) begin
        rd_lookup_data = regs_reg[i];
        rd_lookup_resp = RESP_OKAY;
      end
    end
    if (rd_idx == DISP_IDX) begin
      rd_lookup_data = {28'h0, disp_sel_reg};
      rd_lookup_resp = RESP_OKAY;
    end
  end

  // Read FSM next-state and handshake outputs.
  always_comb begin
    rd_state_next = rd_state_reg;
    ARREADY       = 1'b0;
    RVALID        = 1'b0;
    case (rd_state_reg)
      RD_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) rd_state_next = RD_DATA;
      end
      RD_DATA: begin
        RVALID = 1'b1;
        if (RREADY) rd_state_next = RD_IDLE;
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  // Latch read data/response on the AR handshake so they stay stable until accepted.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
    end else if (rd_state_reg == RD_IDLE && ARVALID) begin
      rdata_reg <= rd_lookup_data;
      rresp_reg <= rd_lookup_resp;
    end
  end

  assign RDATA = rdata_reg;
  assign RRESP = rresp_reg;

  // Selected register for the display; out-of-range selections show zero.
  always_comb begin
    disp_value = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (disp_sel_reg == 4'(i)) disp_value = regs_reg[i];
    end
  end

  SevenSegmentController #(
    .SCAN_BITS(SCAN_BITS)
  ) u_seven_seg (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .value   (disp_value),
    .segment (segment),
    .anode   (anode)
  );

endmodule

// File: tb/tb_axil_seg_regfile.sv
// Directed bench for axil_seg_regfile with a register-map model and a per-cycle display check.
module tb_axil_seg_regfile;

  localparam int         NUM_REGS     = 4;
  localparam logic [3:0] DISP_DEFAULT = 4'd0;

  logic        ACLK, ARESETn;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic [7:0]  segment, anode;

  axil_seg_regfile #(
    .NUM_REGS(NUM_REGS), .DISP_DEFAULT(DISP_DEFAULT), .SCAN_BITS(1)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWPROT(AWPROT),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARPROT(ARPROT),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .segment(segment), .anode(anode)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;
  int b_pulses = 0;
  logic bvalid_prev = 1'b0;
  bit disp_check_en = 1'b0;

  logic [31:0] m_regs [NUM_REGS];
  logic [3:0]  m_disp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Standard hex digit shapes, segments a..g in bits 0..6, lit = 1.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 32'h0;
    m_disp = DISP_DEFAULT;
  endtask

  function automatic logic [31:0] model_disp_value();
    if (int'(m_disp) < NUM_REGS) return m_regs[m_disp];
    return 32'h0;
  endfunction

  task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    int idx;
    idx = int'(addr[5:2]);
    if (idx < NUM_REGS) begin d = m_regs[idx]; r = 2'b00; end
    else if (idx == NUM_REGS) begin d = {28'h0, m_disp}; r = 2'b00; end
    else begin d = 32'h0; r = 2'b10; end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
    int idx;
    idx = int'(addr[5:2]);
    r = 2'b00;
    if (idx < NUM_REGS) begin
      for (int k = 0; k < 4; k++) if (s[k]) m_regs[idx][8*k +: 8] = d[8*k +: 8];
    end else if (idx == NUM_REGS) begin
      if (s[0]) m_disp = d[3:0];
    end else begin
      r = 2'b10;
    end
  endtask

  // Display check every cycle: one active digit, showing the model's selected nibble.
  always @(negedge ACLK) begin
    int dig;
    logic [31:0] v;
    if (disp_check_en && ARESETn) begin
      dig = -1;
      for (int i = 0; i < 8; i++) if (anode == ~(8'b1 << i)) dig = i;
      check("anode_onehot", (dig >= 0), 1);
      if (dig >= 0) begin
        v = model_disp_value();
        check("segment", segment, {1'b1, ~seg_of(v[dig*4 +: 4])});
      end
    end
  end

  // Count BVALID rising edges.
  always @(negedge ACLK) begin
    if (BVALID && !bvalid_prev) b_pulses++;
    bvalid_prev = BVALID;
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_delay, input int w_delay, input int bready_delay,
                           output logic [1:0] resp);
    bit aw_done, w_done, aw_fire, w_fire;
    int k;
    logic [1:0] exp_resp;
    aw_done = 0; w_done = 0; k = 0; exp_resp = 2'b00; resp = 2'bxx;
    @(negedge ACLK);
    AWADDR = addr; WDATA = data; WSTRB = strb;
    while (!(aw_done && w_done) && k < 40) begin
      if (!aw_done && k == aw_delay) AWVALID = 1'b1;
      if (!w_done && k == w_delay) WVALID = 1'b1;
      check("bvalid_early", BVALID, 0);
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      @(posedge ACLK);
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
      if (aw_done && w_done) model_write(addr, data, strb, exp_resp);
      @(negedge ACLK);
      if (aw_fire) AWVALID = 1'b0;
      if (w_fire) WVALID = 1'b0;
      k++;
    end
    check("wr_handshake_done", (aw_done && w_done), 1);
    if (!(aw_done && w_done)) begin
      AWVALID = 1'b0; WVALID = 1'b0;
      return;
    end
    check("bvalid_latency", BVALID, 1);
    for (int i = 0; i < bready_delay; i++) begin
      check("bresp_hold", {BVALID, BRESP}, {1'b1, exp_resp});
      @(negedge ACLK);
    end
    BREADY = 1'b1;
    check("bresp", BRESP, exp_resp);
    resp = BRESP;
    @(posedge ACLK);
    @(negedge ACLK);
    BREADY = 1'b0;
    check("bvalid_drop", BVALID, 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rready_delay,
                          output logic [31:0] data, output logic [1:0] resp);
    bit fired;
    int k;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    fired = 0; k = 0; exp_d = 0; exp_r = 0; data = 'x; resp = 'x;
    @(negedge ACLK);
    ARADDR = addr; ARVALID = 1'b1;
    while (!fired && k < 10) begin
      fired = ARVALID && ARREADY;
      if (fired) model_read(addr, exp_d, exp_r);
      @(posedge ACLK);
      @(negedge ACLK);
      k++;
    end
    ARVALID = 1'b0;
    check("ar_handshake_done", fired, 1);
    if (!fired) return;
    check("rvalid_latency", RVALID, 1);
    for (int i = 0; i < rready_delay; i++) begin
      check("rdata_hold", {RVALID, RRESP, RDATA}, {1'b1, exp_r, exp_d});
      @(negedge ACLK);
    end
    RREADY = 1'b1;
    check("rdata", RDATA, exp_d);
    check("rresp", RRESP, exp_r);
    data = RDATA; resp = RRESP;
    @(posedge ACLK);
    @(negedge ACLK);
    RREADY = 1'b0;
    check("rvalid_drop", RVALID, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d2;
    logic [1:0]  r, r2;
    int p0;
    logic [7:0] seen;
    ARESETn = 1'b0;
    AWADDR = 0; AWVALID = 0; AWPROT = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
    ARADDR = 0; ARVALID = 0; ARPROT = 0; RREADY = 0;
    repeat (3) @(posedge ACLK);
    model_reset();
    @(negedge ACLK);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_bresp", BRESP, 0);
    check("rst_rresp", RRESP, 0);
    check("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
    ARESETn = 1'b1;
    disp_check_en = 1'b1;

    // Simultaneous AW/W, then readback.
    axi_write(32'h4, 32'h12345678, 4'hF, 0, 0, 0, r);
    check("lit_bresp_0x4", r, 2'b00);
    axi_read(32'h4, 0, d, r);
    check("lit_read_0x4", d, 32'h12345678);

    // Partial strobe over a known value.
    axi_write(32'h0, 32'h11111111, 4'hF, 0, 0, 0, r);
    axi_write(32'h0, 32'hAABBCCDD, 4'b0101, 0, 0, 1, r);
    axi_read(32'h0, 2, d, r);
    check("lit_strobe_0x0", d, 32'h11BB11DD);

    // W three cycles ahead of AW: one update, one BVALID pulse.
    p0 = b_pulses;
    axi_write(32'h8, 32'h0BADF00D, 4'hF, 3, 0, 0, r);
    repeat (3) @(negedge ACLK);
    check("lit_one_bpulse", b_pulses - p0, 1);
    axi_read(32'h8, 0, d, r);
    check("lit_read_0x8", d, 32'h0BADF00D);
    // AW ahead of W, response held for two cycles.
    axi_write(32'hC, 32'h5A5A0001, 4'hF, 0, 2, 2, r);
    axi_read(32'hC, 0, d, r);

    // Unmapped accesses.
    axi_read(32'h20, 1, d, r);
    check("lit_unmapped_rresp", r, 2'b10);
    check("lit_unmapped_rdata", d, 32'h0);
    axi_write(32'h24, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r);
    check("lit_unmapped_bresp", r, 2'b10);
    for (int i = 0; i < 5; i++) axi_read(32'(i * 4), 0, d, r);
    axi_read(32'hFFFF_FFC7, 0, d, r);  // index 1 with high/low address bits set

    // Display selection.
    axi_write(32'h8, 32'hCAFEF00D, 4'hF, 0, 0, 0, r);
    axi_write(32'h10, 32'hFFFFFFF2, 4'hF, 0, 0, 0, r);
    check("lit_model_disp", model_disp_value(), 32'hCAFEF00D);
    axi_read(32'h10, 0, d, r);
    check("lit_disp_sel_read", d, 32'h2);
    seen = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      for (int i = 0; i < 8; i++) if (anode == ~(8'b1 << i)) seen[i] = 1'b1;
      if (anode == 8'h7F) check("lit_digit7_C", segment, 8'hC6);
      if (anode == 8'hFE) check("lit_digit0_D", segment, 8'hA1);
    end
    check("lit_all_digits", seen, 8'hFF);
    axi_write(32'h10, 32'h5, 4'h1, 0, 0, 0, r);
    repeat (3) @(negedge ACLK);
    check("lit_disp_oor_zero", segment, 8'hC0);
    axi_write(32'h10, 32'h2, 4'h1, 0, 0, 0, r);

    // Read and write of the same register in the same cycle.
    fork
      axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, r2);
      axi_read(32'h4, 0, d2, r);
    join
    check("lit_read_prewrite", d2, 32'h12345678);
    axi_read(32'h4, 0, d, r);
    check("lit_read_postwrite", d, 32'hDEADBEEF);

    // Reset while the write FSM holds an address.
    @(negedge ACLK);
    AWADDR = 32'h8; WDATA = 32'h77777777; WSTRB = 4'hF; AWVALID = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 1'b0;
    check("wr_addr_state", {AWREADY, WREADY}, 2'b01);
    ARESETn = 1'b0;
    @(posedge ACLK);
    model_reset();
    @(negedge ACLK);
    check("midrst_outputs", {BVALID, RVALID, BRESP, RRESP, RDATA}, 38'h0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    p0 = b_pulses;
    repeat (5) begin
      @(negedge ACLK);
      check("midrst_no_bvalid", BVALID, 0);
    end
    check("midrst_no_bpulse", b_pulses - p0, 0);
    axi_read(32'h8, 0, d, r);
    check("lit_midrst_reg8", d, 32'h0);
    axi_write(32'h8, 32'h600DCAFE, 4'hF, 0, 0, 0, r);
    check("lit_post_rst_bresp", r, 2'b00);
    axi_read(32'h8, 0, d, r);
    check("lit_post_rst_read", d, 32'h600DCAFE);
    for (int i = 0; i < 5; i++) axi_read(32'(i * 4), 0, d, r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
